// File: rtl/instr_issuer_pkg.sv
// Shared definitions for the instruction issuer: word width, opcode field
// position and the controller state encoding.
package instr_issuer_pkg;

  localparam int WORD_W  = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  // Extract the opcode field of an instruction word.
  function automatic logic [OPC_W-1:0] opcode_of(input word_t w);
    return w[OPC_MSB:OPC_LSB];
  endfunction

  // Even parity over an instruction word.
  function automatic logic parity_of(input word_t w);
    return ^w;
  endfunction

endpackage

// File: rtl/instr_issuer_prog_mem.sv
// Program memory: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module prog_mem
  import instr_issuer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  word_t         wdata,
  input  logic [AW-1:0] raddr,
  output word_t         rdata
);

  word_t mem_r [DEPTH];

  // Write one instruction word on the rising edge when enabled.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/instr_issuer.sv
// Instruction issuer: streams a loaded program to a processor one word at a
// time, waiting for a done handshake per word, with a per-word timeout.
module instr_issuer
  import instr_issuer_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [WORD_W-1:0]       load_data,
  input  logic [$clog2(DEPTH):0]  prog_len,
  input  logic                    start,
  input  logic                    done,
  input  logic [WORD_W-1:0]       bus,
  output logic [WORD_W-1:0]       iin,
  output logic                    run,
  output logic                    busy,
  output logic                    finished,
  output logic                    error,
  output logic [WORD_W-1:0]       result,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_V   = CW'(DEPTH);
  localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);

  state_e         state_r;
  state_e         state_s;
  logic [AW-1:0]  pc_r;
  logic [CW-1:0]  len_r;
  logic [CW-1:0]  count_r;
  logic [TW-1:0]  timer_r;
  word_t          iin_r;
  word_t          result_r;
  logic           run_r;
  logic           busy_r;
  logic           finished_r;
  logic           error_r;

  word_t          mem_rdata_s;
  logic           start_ok_s;
  logic [CW-1:0]  len_clamp_s;
  logic [CW-1:0]  count_inc_s;
  logic [TW-1:0]  timer_inc_s;
  logic           mem_we_s;

  // Writes are only allowed while no program is in flight.
  assign mem_we_s = load_en & ~busy_r;

  prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_mem (
    .clock (clock),
    .we    (mem_we_s),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc_r),
    .rdata (mem_rdata_s)
  );

  // Start qualification, length clamp and increment helpers.
  always_comb begin
    start_ok_s  = 1'b0;
    len_clamp_s = prog_len;
    count_inc_s = count_r + 1'b1;
    timer_inc_s = timer_r + 1'b1;
    if (start && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERROR))) begin
      start_ok_s = 1'b1;
    end else begin
      start_ok_s = 1'b0;
    end
    if (prog_len > DEPTH_V) begin
      len_clamp_s = DEPTH_V;
    end else begin
      len_clamp_s = prog_len;
    end
  end

  // Next-state logic for the issue controller.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_ok_s) begin
          if (len_clamp_s == {CW{1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_ISSUE;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_ISSUE: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (done) begin
          if (count_inc_s == len_r) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_ISSUE;
          end
        end else if (timer_inc_s == TIMEOUT_V) begin
          state_s = ST_ERROR;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered status flags derived from the next state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      run_r      <= 1'b0;
      busy_r     <= 1'b0;
      finished_r <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      run_r      <= (state_r == ST_ISSUE);
      busy_r     <= (state_s == ST_ISSUE) || (state_s == ST_WAIT);
      finished_r <= (state_s == ST_DONE);
      error_r    <= (state_s == ST_ERROR);
    end
  end

  // Program counter, length, completion count and wait timer.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc_r    <= {AW{1'b0}};
      len_r   <= {CW{1'b0}};
      count_r <= {CW{1'b0}};
      timer_r <= {TW{1'b0}};
    end else if (start_ok_s) begin
      pc_r    <= {AW{1'b0}};
      len_r   <= len_clamp_s;
      count_r <= {CW{1'b0}};
      timer_r <= {TW{1'b0}};
    end else if (state_r == ST_ISSUE) begin
      timer_r <= {TW{1'b0}};
    end else if (state_r == ST_WAIT) begin
      if (done) begin
        pc_r    <= pc_r + 1'b1;
        count_r <= count_inc_s;
        timer_r <= {TW{1'b0}};
      end else if (timer_r != TIMEOUT_V) begin
        timer_r <= timer_inc_s;
      end
    end
  end

  // Instruction word to the processor and the captured bus result.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      iin_r    <= {WORD_W{1'b0}};
      result_r <= {WORD_W{1'b0}};
    end else begin
      if (state_r == ST_ISSUE) begin
        iin_r <= mem_rdata_s;
      end
      if ((state_r == ST_WAIT) && done) begin
        result_r <= bus;
      end
    end
  end

  assign iin      = iin_r;
  assign run      = run_r;
  assign busy     = busy_r;
  assign finished = finished_r;
  assign error    = error_r;
  assign result   = result_r;
  assign count    = count_r;

endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench for instr_issuer: directed scenarios plus randomized
// programs checked against a word-list model of the issue sequence.
module tb_instr_issuer;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 15;
  localparam int AW      = 4;
  localparam int CW      = 5;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [15:0]   load_data = '0;
  logic [CW-1:0] prog_len = '0;
  logic          start = 1'b0;
  logic          done = 1'b0;
  logic [15:0]   bus = '0;
  logic [15:0]   iin;
  logic          run;
  logic          busy;
  logic          finished;
  logic          error;
  logic [15:0]   result;
  logic [CW-1:0] count;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            runs    = 0;
  logic [15:0]   model_mem [DEPTH];
  logic [15:0]   exp_result = '0;

  instr_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .resetn(resetn), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .start(start), .done(done),
    .bus(bus), .iin(iin), .run(run), .busy(busy), .finished(finished),
    .error(error), .result(result), .count(count)
  );

  always #5 clock = ~clock;

  // Count run pulses away from the active edge.
  always @(negedge clock) if (run) runs++;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input int a, input logic [15:0] d);
    load_en = 1'b1; load_addr = AW'(a); load_data = d;
    step();
    load_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic start_prog(input int len);
    start = 1'b1; prog_len = CW'(len);
    step();
    start = 1'b0;
  endtask

  task automatic wait_run(output bit ok);
    for (int k = 0; k < 8 && !run; k++) step();
    ok = run;
  endtask

  task automatic pulse_done(input int dly, input logic [15:0] v);
    repeat (dly) step();
    done = 1'b1; bus = v;
    step();
    done = 1'b0; bus = 16'($urandom);
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_tests++; if ({iin, result} !== 32'h0) begin n_fail++; $display("FAIL reset_data iin=%h result=%h want 0", iin, result); end
    n_tests++; if ({run, busy, finished, error} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got=%b want 0000", {run, busy, finished, error}); end
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got=%0d want 0", count); end
    resetn = 1'b1;
    step();
    for (int i = 0; i < DEPTH; i++) load_word(i, 16'($urandom));
  endtask

  task automatic test_spec_program();
    bit ok; int base;
    load_word(0, 16'hA001); load_word(1, 16'hA400); load_word(2, 16'h4400);
    base = runs;
    start_prog(3);
    for (int i = 0; i < 3; i++) begin
      wait_run(ok);
      n_tests++; if (!ok || iin !== model_mem[i]) begin n_fail++; $display("FAIL spec_iin[%0d] got=%h run=%b want %h", i, iin, ok, model_mem[i]); end
      pulse_done(2, 16'(i + 1));
    end
    step();
    n_tests++; if (runs - base !== 3) begin n_fail++; $display("FAIL spec_runs got=%0d want 3", runs - base); end
    n_tests++; if (result !== 16'h0003 || count !== 5'd3) begin n_fail++; $display("FAIL spec_result result=%h count=%0d want 0003/3", result, count); end
    n_tests++; if (finished !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL spec_finished fin=%b busy=%b want 1/0", finished, busy); end
    n_tests++; if (iin !== 16'h4400) begin n_fail++; $display("FAIL spec_iin_hold got=%h want 4400", iin); end
    exp_result = 16'h0003;
  endtask

  task automatic test_zero_len();
    int base;
    base = runs;
    start_prog(0);
    n_tests++; if (finished !== 1'b1 || count !== 5'd0) begin n_fail++; $display("FAIL zero_len fin=%b count=%0d want 1/0", finished, count); end
    repeat (3) step();
    n_tests++; if (runs !== base || result !== exp_result) begin n_fail++; $display("FAIL zero_len_quiet runs=%0d result=%h want %0d/%h", runs - base, result, 0, exp_result); end
  endtask

  task automatic test_timeout();
    bit ok;
    start_prog(2);
    repeat (TIMEOUT) step();
    n_tests++; if (error !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL timeout_early err=%b busy=%b want 0/1", error, busy); end
    step();
    n_tests++; if (error !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL timeout_err err=%b busy=%b want 1/0", error, busy); end
    n_tests++; if (count !== 5'd0 || result !== exp_result) begin n_fail++; $display("FAIL timeout_hold count=%0d result=%h want 0/%h", count, result, exp_result); end
    start_prog(1);
    wait_run(ok);
    exp_result = 16'($urandom);
    pulse_done(1, exp_result);
    n_tests++; if (!ok || error !== 1'b0 || finished !== 1'b1 || count !== 5'd1 || result !== exp_result) begin
      n_fail++; $display("FAIL timeout_recover run=%b err=%b fin=%b count=%0d result=%h want 1/0/1/1/%h", ok, error, finished, count, result, exp_result);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int base;
    start_prog(4);
    wait_run(ok);
    pulse_done(1, 16'h1234);
    wait_run(ok);
    step();
    #2 resetn = 1'b0;
    #1;
    n_tests++; if (iin !== 16'h0 || run !== 1'b0 || busy !== 1'b0 || count !== 5'd0 || result !== 16'h0) begin
      n_fail++; $display("FAIL reset_mid iin=%h run=%b busy=%b count=%0d result=%h want 0", iin, run, busy, count, result);
    end
    exp_result = 16'h0;
    base = runs;
    repeat (4) step();
    resetn = 1'b1;
    repeat (3) step();
    n_tests++; if (runs !== base || busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_quiet runs=%0d busy=%b want 0/0", runs - base, busy); end
    start_prog(4);
    for (int i = 0; i < 4; i++) begin
      wait_run(ok);
      n_tests++; if (!ok || iin !== model_mem[i]) begin n_fail++; $display("FAIL reset_restart_iin[%0d] got=%h want %h", i, iin, model_mem[i]); end
      exp_result = 16'($urandom);
      pulse_done(int'($urandom_range(0, 3)), exp_result);
    end
    n_tests++; if (count !== 5'd4 || finished !== 1'b1) begin n_fail++; $display("FAIL reset_restart_done count=%0d fin=%b want 4/1", count, finished); end
  endtask

  task automatic test_busy_ignore();
    bit ok;
    start_prog(3);
    wait_run(ok);
    exp_result = 16'($urandom);
    pulse_done(0, exp_result);
    load_en = 1'b1; load_addr = '0; load_data = ~model_mem[0];
    start = 1'b1; prog_len = 5'd1;
    step();
    load_en = 1'b0; start = 1'b0;
    n_tests++; if (count !== 5'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL busy_start count=%0d busy=%b want 1/1", count, busy); end
    for (int i = 1; i < 3; i++) begin
      wait_run(ok);
      n_tests++; if (!ok || iin !== model_mem[i]) begin n_fail++; $display("FAIL busy_iin[%0d] got=%h want %h", i, iin, model_mem[i]); end
      exp_result = 16'($urandom);
      pulse_done(1, exp_result);
    end
    n_tests++; if (count !== 5'd3 || finished !== 1'b1) begin n_fail++; $display("FAIL busy_done count=%0d fin=%b want 3/1", count, finished); end
    start_prog(1);
    wait_run(ok);
    n_tests++; if (!ok || iin !== model_mem[0]) begin n_fail++; $display("FAIL busy_load_dropped got=%h want %h", iin, model_mem[0]); end
    exp_result = 16'($urandom);
    pulse_done(0, exp_result);
  endtask

  task automatic test_load_start();
    bit ok; logic [15:0] w;
    resetn = 1'b0; step(); resetn = 1'b1; step();
    exp_result = 16'h0;
    w = 16'($urandom);
    load_en = 1'b1; load_addr = '0; load_data = w;
    start = 1'b1; prog_len = 5'd1;
    step();
    load_en = 1'b0; start = 1'b0;
    model_mem[0] = w;
    wait_run(ok);
    n_tests++; if (!ok || iin !== w) begin n_fail++; $display("FAIL load_start_iin got=%h want %h", iin, w); end
    exp_result = 16'($urandom);
    pulse_done(0, exp_result);
  endtask

  task automatic test_back_to_back();
    int nb; logic [15:0] v;
    v = 16'($urandom);
    done = 1'b1; bus = v;
    start_prog(4);
    nb = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      n_tests++; if (run !== 1'(nb % 2)) begin n_fail++; $display("FAIL b2b_run[%0d] got=%b want %b", nb, run, 1'(nb % 2)); end
      nb++;
      step();
    end
    exp_result = v;
    n_tests++; if (nb !== 8 || count !== 5'd4 || finished !== 1'b1) begin n_fail++; $display("FAIL b2b_cycles cycles=%0d count=%0d fin=%b want 8/4/1", nb, count, finished); end
    bus = ~v;
    repeat (2) step();
    done = 1'b0;
    n_tests++; if (result !== exp_result || count !== 5'd4) begin n_fail++; $display("FAIL b2b_done_ignored result=%h count=%0d want %h/4", result, count, exp_result); end
  endtask

  task automatic test_random();
    bit ok; int req, len, base;
    for (int it = 0; it < 8; it++) begin
      for (int j = 0; j < 3; j++) load_word(int'($urandom_range(0, DEPTH - 1)), 16'($urandom));
      req = (it == 0) ? 31 : int'($urandom_range(0, 31));
      len = (req > DEPTH) ? DEPTH : req;
      base = runs;
      start_prog(req);
      for (int i = 0; i < len; i++) begin
        wait_run(ok);
        n_tests++; if (!ok || iin !== model_mem[i]) begin n_fail++; $display("FAIL rand%0d_iin[%0d] got=%h want %h", it, i, iin, model_mem[i]); end
        exp_result = 16'($urandom);
        pulse_done(int'($urandom_range(0, 4)), exp_result);
      end
      step();
      n_tests++; if (count !== CW'(len) || result !== exp_result || finished !== 1'b1 || runs - base !== len) begin
        n_fail++; $display("FAIL rand%0d_end count=%0d result=%h fin=%b runs=%0d want %0d/%h/1/%0d", it, count, result, finished, runs - base, len, exp_result, len);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_spec_program();
    test_zero_len();
    test_timeout();
    test_reset_mid();
    test_busy_ignore();
    test_load_start();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
